// File: rtl/load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : load_scoreboard
// Brief    : In-order outstanding-load queue with RAW hazard detection and
//            register-file write-port arbitration between ALU and load return.
// Revision : 1.0 - initial release
// ============================================================================
module load_scoreboard #(
    parameter int NREG   = 16,
    parameter int REG_W  = $clog2(NREG),
    parameter int MAX_LD = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        issue_valid,
    input  logic [REG_W-1:0]            issue_rs1,
    input  logic [REG_W-1:0]            issue_rs2,
    input  logic                        issue_use_rs1,
    input  logic                        issue_use_rs2,
    input  logic                        issue_is_load,
    input  logic                        issue_is_store,
    input  logic [REG_W-1:0]            issue_rd,
    input  logic                        is_writeback,
    input  logic                        ld_valid,
    output logic                        issue_ok,
    output logic                        ld_en,
    output logic                        st_en,
    output logic                        fetch_stall,
    output logic                        reg_we,
    output logic                        reg_wsel,
    output logic [REG_W-1:0]            ld_rd,
    output logic [$clog2(MAX_LD+1)-1:0] pending,
    output logic                        ld_underflow
);

    localparam int C_PTR_W = (MAX_LD > 1) ? $clog2(MAX_LD) : 1;
    localparam int C_CNT_W = $clog2(MAX_LD + 1);
    localparam logic [C_PTR_W-1:0] C_LAST_PTR = C_PTR_W'(MAX_LD - 1);
    localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(MAX_LD);

    logic [REG_W-1:0]   r_q [MAX_LD];
    logic [MAX_LD-1:0]  r_v;
    logic [C_PTR_W-1:0] r_head;
    logic [C_PTR_W-1:0] r_tail;
    logic [C_CNT_W-1:0] r_count;
    logic               r_underflow;

    logic [MAX_LD-1:0]  w_rs1_hit;
    logic [MAX_LD-1:0]  w_rs2_hit;
    logic               w_hazard;
    logic               w_nonempty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_wb_conflict;
    logic               w_issue_ok;

    function automatic logic [C_PTR_W-1:0] f_next(input logic [C_PTR_W-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Every valid entry is compared, including the one being popped this cycle.
    for (genvar gi = 0; gi < MAX_LD; gi++) begin : g_match
        assign w_rs1_hit[gi] = r_v[gi] && (r_q[gi] == issue_rs1);
        assign w_rs2_hit[gi] = r_v[gi] && (r_q[gi] == issue_rs2);
    end

    assign w_hazard = issue_valid &
                      ((issue_use_rs1 & (issue_rs1 != '0) & (|w_rs1_hit)) |
                       (issue_use_rs2 & (issue_rs2 != '0) & (|w_rs2_hit)));

    assign w_nonempty    = (r_count != '0);
    assign w_full        = (r_count == C_FULL_CNT);
    assign w_pop         = ld_valid & w_nonempty;
    assign w_wb_conflict = ld_valid & is_writeback & ~flush;
    assign w_issue_ok    = issue_valid & ~flush & ~w_hazard & ~w_wb_conflict &
                           ~(issue_is_load & w_full & ~ld_valid);
    assign w_push        = w_issue_ok & issue_is_load;

    assign issue_ok     = w_issue_ok;
    assign ld_en        = w_push;
    assign st_en        = w_issue_ok & issue_is_store;
    assign fetch_stall  = w_wb_conflict | (issue_valid & ~flush & ~w_issue_ok);
    assign reg_we       = w_pop | (is_writeback & ~flush);
    assign reg_wsel     = w_pop;
    assign ld_rd        = w_nonempty ? r_q[r_head] : '0;
    assign pending      = r_count;
    assign ld_underflow = r_underflow;

    // Push follows pop so a simultaneous push/pop on a full queue keeps the slot valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LD; i++) begin
                r_q[i] <= '0;
            end
            r_v         <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_v[r_head] <= 1'b0;
                r_head      <= f_next(r_head);
            end
            if (w_push) begin
                r_q[r_tail] <= issue_rd;
                r_v[r_tail] <= 1'b1;
                r_tail      <= f_next(r_tail);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (ld_valid & ~w_nonempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_scoreboard
// Brief    : Directed scoreboard bench for load_scoreboard (MAX_LD = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       issue_valid = 1'b0;
    logic [3:0] issue_rs1 = '0;
    logic [3:0] issue_rs2 = '0;
    logic       issue_use_rs1 = 1'b0;
    logic       issue_use_rs2 = 1'b0;
    logic       issue_is_load = 1'b0;
    logic       issue_is_store = 1'b0;
    logic [3:0] issue_rd = '0;
    logic       is_writeback = 1'b0;
    logic       ld_valid = 1'b0;
    logic       issue_ok, ld_en, st_en, fetch_stall, reg_we, reg_wsel, ld_underflow;
    logic [3:0] ld_rd;
    logic [2:0] pending;

    load_scoreboard #(.NREG(16), .REG_W(4), .MAX_LD(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_is_load(issue_is_load), .issue_is_store(issue_is_store),
        .issue_rd(issue_rd), .is_writeback(is_writeback), .ld_valid(ld_valid),
        .issue_ok(issue_ok), .ld_en(ld_en), .st_en(st_en),
        .fetch_stall(fetch_stall), .reg_we(reg_we), .reg_wsel(reg_wsel),
        .ld_rd(ld_rd), .pending(pending), .ld_underflow(ld_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [13:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        n_checks = 0;
    int        n_errors = 0;

    // Packed order: ok, ld_en, st_en, fetch_stall, reg_we, reg_wsel, ld_rd, pending, underflow
    function automatic logic [13:0] e(input logic ok, le, se, fs, we, ws,
                                      input logic [3:0] rd, input logic [2:0] p,
                                      input logic uf);
        return {ok, le, se, fs, we, ws, rd, p, uf};
    endfunction

    task automatic step(input string nm, input logic r, fl, iv,
                        input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2,
                        input logic ld, st, input logic [3:0] rd,
                        input logic wb, lv, input logic [13:0] exp);
        sb_entry_t s;
        @(posedge clk);
        #1;
        rst = r; flush = fl; issue_valid = iv;
        issue_rs1 = r1; issue_use_rs1 = u1; issue_rs2 = r2; issue_use_rs2 = u2;
        issue_is_load = ld; issue_is_store = st; issue_rd = rd;
        is_writeback = wb; ld_valid = lv;
        s.name = nm;
        s.exp  = exp;
        sb.push_back(s);
    endtask

    // Monitor: outputs are combinational, so they are presented every cycle.
    initial begin
        sb_entry_t s;
        logic [13:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                s   = sb.pop_front();
                got = {issue_ok, ld_en, st_en, fetch_stall, reg_we, reg_wsel,
                       ld_rd, pending, ld_underflow};
                n_checks++;
                if (got !== s.exp) begin
                    n_errors++;
                    $display("FAIL %s: got %b expected %b (ok,ld,st,fs,we,ws,rd4,pend3,uf)",
                             s.name, got, s.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //   name            rst fl iv r1 u1 r2 u2 ld st rd wb lv  expected
        step("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0));
        // basic load-use
        step("ld5",          0, 0, 1, 0, 0, 0, 0, 1, 0, 5, 0, 0, e(1,1,0,0,0,0,0,0,0));
        step("use5_stall",   0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,1,0,0,5,1,0));
        step("use5_return",  0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,1,1,1,5,1,0));
        step("use5_issue",   0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, e(1,0,0,0,0,0,0,0,0));
        // fill, full, push+pop while full across pointer wrap
        step("fill1",        0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, e(1,1,0,0,0,0,0,0,0));
        step("fill2",        0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0, e(1,1,0,0,0,0,1,1,0));
        step("fill3",        0, 0, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0, e(1,1,0,0,0,0,1,2,0));
        step("fill4",        0, 0, 1, 0, 0, 0, 0, 1, 0, 4, 0, 0, e(1,1,0,0,0,0,1,3,0));
        step("full_block",   0, 0, 1, 0, 0, 0, 0, 1, 0, 6, 0, 0, e(0,0,0,1,0,0,1,4,0));
        step("full_pushpop", 0, 0, 1, 0, 0, 0, 0, 1, 0, 6, 0, 1, e(1,1,0,0,1,1,1,4,0));
        step("haz_tail_rs2", 0, 0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, e(0,0,0,1,0,0,2,4,0));
        // write-port conflict
        step("wb_conflict",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, e(0,0,0,1,1,1,2,4,0));
        step("wb_retry",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, e(0,0,0,0,1,0,3,3,0));
        step("drain3",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,0,1,1,3,3,0));
        // flush with two pending
        step("flush",        0, 1, 1, 0, 0, 0, 0, 1, 0, 9, 1, 0, e(0,0,0,0,0,0,4,2,0));
        step("flush_ret4",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,0,1,1,4,2,0));
        step("flush_ret6",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,0,1,1,6,1,0));
        step("empty",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0));
        // x0 and WAW
        step("ld_x0",        0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, e(1,1,0,0,0,0,0,0,0));
        step("st_rs2_x0",    0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, e(1,0,1,0,0,0,0,1,0));
        step("ret_x0",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,0,1,1,0,1,0));
        step("ld7_a",        0, 0, 1, 0, 0, 0, 0, 1, 0, 7, 0, 0, e(1,1,0,0,0,0,0,0,0));
        step("ld7_b_waw",    0, 0, 1, 0, 0, 0, 0, 1, 0, 7, 0, 0, e(1,1,0,0,0,0,7,1,0));
        step("rs7_unused",   0, 0, 1, 7, 0, 7, 0, 0, 0, 0, 0, 0, e(1,0,0,0,0,0,7,2,0));
        step("rs2_7_haz",    0, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, e(0,0,0,1,0,0,7,2,0));
        step("ret7_a",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,0,1,1,7,2,0));
        step("ret7_b",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,0,1,1,7,1,0));
        // underflow and mid-run reset
        step("underflow",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,0,0,0,0,0,0));
        step("uf_sticky",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,1));
        step("uf_ld1",       0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, e(1,1,0,0,0,0,0,0,1));
        step("uf_ld2",       0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0, e(1,1,0,0,0,0,1,1,1));
        step("uf_ld3",       0, 0, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0, e(1,1,0,0,0,0,1,2,1));
        step("async_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0));
        step("post_rst_ret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,0,0,0,0,0,0));
        step("post_rst_uf",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,1));
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
